// File: rtl/key_conditioner.sv
// key_conditioner
//   Turns the raw, bouncing, asynchronous push-button levels (active-low) into
//   clean clk-domain signals. Each key has its own 2-flop synchroniser, debounce
//   counter and four-state FSM, so keys never interact.
//
//   Optional feature (compile-time macro KEY_AUTOREPEAT_EN):
//     while a key stays pressed, emit an extra key_press after REPEAT_DELAY
//     cycles and then every REPEAT_PERIOD cycles.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   key_n        in   [NUM_KEYS] raw button levels, 0 = pressed
//   key_level    out  [NUM_KEYS] debounced level, 1 = pressed
//   key_press    out  [NUM_KEYS] one-cycle pulse per accepted press (plus repeats)
//   key_release  out  [NUM_KEYS] one-cycle pulse per accepted release
module key_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`endif

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
    $error("key_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    // Sync flops hold the raw active-low level; reset value 1 means released.
    logic [1:0]    r_sync;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          w_s;
`ifdef KEY_AUTOREPEAT_EN
    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_armed;   // first repeat already emitted; use period
`endif

    assign w_s = ~r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync      <= '1;
        r_state     <= ST_RELEASED;
        r_cnt       <= '0;
        r_level     <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b0;
`endif
      end else begin
        r_sync    <= {r_sync[0], key_n[i]};
        r_press   <= 1'b0;
        r_release <= 1'b0;
        case (r_state)
          ST_RELEASED: begin
            r_cnt <= '0;
            if (w_s) r_state <= ST_PRESS_WAIT;
          end
          ST_PRESS_WAIT: begin
            if (!w_s) begin
              r_state <= ST_RELEASED;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= ST_PRESSED;
              r_cnt   <= '0;
              r_press <= 1'b1;
              r_level <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
              r_rep_cnt   <= '0;
              r_rep_armed <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          ST_PRESSED: begin
            if (!w_s) begin
              r_state <= ST_RELEASE_WAIT;
              r_cnt   <= '0;
            end else begin
`ifdef KEY_AUTOREPEAT_EN
              // Repeat only fires on cycles the key is still seen held.
              if (r_rep_cnt == (r_rep_armed ? PERIOD_LAST : DELAY_LAST)) begin
                r_press     <= 1'b1;
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b1;
              end else begin
                r_rep_cnt <= r_rep_cnt + RW'(1);
              end
`endif
            end
          end
          default: begin // ST_RELEASE_WAIT: repeat counter holds its value here
            if (w_s) begin
              r_state <= ST_PRESSED;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state   <= ST_RELEASED;
              r_cnt     <= '0;
              r_release <= 1'b1;
              r_level   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
              r_rep_cnt   <= '0;
              r_rep_armed <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        endcase
      end
    end

    assign key_level[i]   = r_level;
    assign key_press[i]   = r_press;
    assign key_release[i] = r_release;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner
//   Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
//   REPEAT_PERIOD=3. Inputs change just after a falling edge; outputs are
//   sampled on falling edges, so "edge k" below is the k-th rising edge after
//   the input change and the check right after it sees the registered result.
module tb_key_conditioner;
  localparam int NK = 3;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int LAT = DB + 3;   // press/release pulse follows this edge

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] level;
  logic [NK-1:0] press;
  logic [NK-1:0] rel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .key_level(level),
    .key_press(press),
    .key_release(rel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [NK-1:0] lvl,
                           input logic [NK-1:0] prs, input logic [NK-1:0] rls);
    check({tag, " level"},   level, lvl);
    check({tag, " press"},   press, prs);
    check({tag, " release"}, rel,   rls);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Apply a new key_n and watch LAT+1 edges: the masked keys must pulse
  // (press or release) on exactly edge LAT, with level changing there.
  task automatic accept(input string tag, input logic [NK-1:0] kn,
                        input logic [NK-1:0] mask, input bit is_press,
                        input logic [NK-1:0] lvl0);
    logic [NK-1:0] lvl_after;
    key_n = kn;
    lvl_after = is_press ? (lvl0 | mask) : (lvl0 & ~mask);
    for (int j = 1; j <= LAT + 1; j++) begin
      step();
      check_out(tag, (j >= LAT) ? lvl_after : lvl0,
                (is_press && j == LAT) ? mask : '0,
                (!is_press && j == LAT) ? mask : '0);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_out("reset", '0, '0, '0);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check_out("idle", '0, '0, '0);
    end

    // 1. clean press on key 0, 3. release
    accept("t1 press", 3'b110, 3'b001, 1'b1, 3'b000);
    accept("t3 release", 3'b111, 3'b001, 1'b0, 3'b001);

    // 2. bounce on key 1: low 3 edges, high 1 edge, then held low
    key_n = 3'b101;
    for (int j = 0; j < 3; j++) begin
      step();
      check_out("t2 burst", '0, '0, '0);
    end
    key_n = 3'b111;
    step();
    check_out("t2 gap", '0, '0, '0);
    accept("t2 press", 3'b101, 3'b010, 1'b1, 3'b000);
    accept("t2 release", 3'b111, 3'b010, 1'b0, 3'b010);

    // 4. simultaneous keys 0 and 2
    accept("t4 press", 3'b010, 3'b101, 1'b1, 3'b000);
    accept("t4 release", 3'b111, 3'b101, 1'b0, 3'b101);

    // 5. reset mid-operation: key 2 fully pressed, key 0 in PRESS_WAIT (cnt=2)
    accept("t5 pre", 3'b011, 3'b100, 1'b1, 3'b000);
    key_n = 3'b010;
    for (int j = 0; j < 5; j++) begin
      step();
      check_out("t5 wait", 3'b100, '0, '0);
    end
    rst = 1'b1;
    #1;
    check_out("t5 async", '0, '0, '0);
    for (int j = 0; j < 2; j++) begin
      step();
      check_out("t5 in rst", '0, '0, '0);
    end
    rst = 1'b0;
    accept("t5 after", 3'b010, 3'b101, 1'b1, 3'b000);
    accept("t5 release", 3'b111, 3'b101, 1'b0, 3'b101);

    // 6. hold key 0 for 40 cycles after acceptance, then release.
    //    The FSM still sees the key held for 2 edges after key_n rises.
    key_n = 3'b110;
    for (int j = 1; j <= LAT; j++) begin
      step();
      check_out("t6 accept", (j == LAT) ? 3'b001 : 3'b000,
                (j == LAT) ? 3'b001 : 3'b000, '0);
    end
    for (int m = 1; m <= 40 + LAT + 2; m++) begin
      logic [NK-1:0] exp_p;
      exp_p = '0;
`ifdef KEY_AUTOREPEAT_EN
      if (m >= RD && m <= 42 && ((m - RD) % RP) == 0) exp_p = 3'b001;
`endif
      step();
      check_out("t6 hold", (m < 40 + LAT) ? 3'b001 : 3'b000, exp_p,
                (m == 40 + LAT) ? 3'b001 : 3'b000);
      if (m == 40) key_n = 3'b111;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
